// File: rtl/fdl_thermo_ctrl.sv
// rtl/fdl_thermo_ctrl.sv - fine delay line thermometer-code loop controller
// Ports:
//   clk_in       rising-edge clock
//   rst          synchronous active-high reset
//   en           loop enable
//   pd_up/pd_dn  phase detector requests for more/less delay
//   Q            registered thermometer code to the FDL, ones filled from the MSB
//   update       one-cycle pulse when Q changes
//   coarse_inc   one-cycle pulse when the fine range wraps upward
//   coarse_dec   one-cycle pulse when the fine range wraps downward
//   lock         registered; loop is dithering around its final position
module fdl_thermo_ctrl #(
   parameter int FILT_LEN = 8,
   parameter int VOTE_TH  = 5,
   parameter int SETTLE   = 4,
   parameter int LOCK_CNT = 4
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       en,
   input  logic       pd_up,
   input  logic       pd_dn,
   output logic [5:0] Q,
   output logic       update,
   output logic       coarse_inc,
   output logic       coarse_dec,
   output logic       lock
);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DECIDE, S_SETTLE} state_t;
   typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

   localparam logic [7:0]  SMP_LAST = 8'(FILT_LEN - 1);
   localparam logic [7:0]  VOTE     = 8'(VOTE_TH);
   localparam logic [15:0] SET_LAST = 16'(SETTLE - 1);
   localparam logic [7:0]  LOCK_TH  = 8'(LOCK_CNT);
   localparam logic [5:0]  ALL_ONES = 6'h3F;

   state_t      state_q, state_d;
   dir_t        last_dir_q, last_dir_d;
   logic [7:0]  smp_cnt_q, smp_cnt_d;
   logic [7:0]  up_cnt_q, up_cnt_d;
   logic [7:0]  dn_cnt_q, dn_cnt_d;
   logic [15:0] set_cnt_q, set_cnt_d;
   logic [7:0]  rev_cnt_q, rev_cnt_d;
   logic [2:0]  lvl_q, lvl_d;
   logic [5:0]  q_q, q_d;
   logic        update_q, update_d;
   logic        coarse_inc_q, coarse_inc_d;
   logic        coarse_dec_q, coarse_dec_d;
   logic        lock_q, lock_d;
   logic [7:0]  rev_inc;

   always_comb begin
      state_d      = state_q;
      last_dir_d   = last_dir_q;
      smp_cnt_d    = smp_cnt_q;
      up_cnt_d     = up_cnt_q;
      dn_cnt_d     = dn_cnt_q;
      set_cnt_d    = set_cnt_q;
      rev_cnt_d    = rev_cnt_q;
      lvl_d        = lvl_q;
      lock_d       = lock_q;
      update_d     = 1'b0;
      coarse_inc_d = 1'b0;
      coarse_dec_d = 1'b0;
      // saturating increment so rev_cnt never wraps back below the lock threshold
      rev_inc      = (rev_cnt_q < LOCK_TH) ? rev_cnt_q + 8'd1 : rev_cnt_q;

      if (!en) begin
         // dropping enable discards the window; position and direction history survive
         state_d   = S_IDLE;
         rev_cnt_d = 8'd0;
         lock_d    = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d   = S_ACCUM;
               smp_cnt_d = 8'd0;
               up_cnt_d  = 8'd0;
               dn_cnt_d  = 8'd0;
            end
            S_ACCUM: begin
               smp_cnt_d = smp_cnt_q + 8'd1;
               if (pd_up && !pd_dn) up_cnt_d = up_cnt_q + 8'd1;
               if (pd_dn && !pd_up) dn_cnt_d = dn_cnt_q + 8'd1;
               if (smp_cnt_q == SMP_LAST) state_d = S_DECIDE;
            end
            S_DECIDE: begin
               state_d   = S_SETTLE;
               set_cnt_d = 16'd0;
               if (up_cnt_q >= VOTE) begin
                  update_d   = 1'b1;
                  last_dir_d = DIR_UP;
                  if (lvl_q == 3'd6) begin
                     lvl_d        = 3'd0;
                     coarse_inc_d = 1'b1;
                     rev_cnt_d    = 8'd0;
                  end else begin
                     lvl_d     = lvl_q + 3'd1;
                     rev_cnt_d = (last_dir_q == DIR_DN) ? rev_inc : 8'd0;
                  end
               end else if (dn_cnt_q >= VOTE) begin
                  update_d   = 1'b1;
                  last_dir_d = DIR_DN;
                  if (lvl_q == 3'd0) begin
                     lvl_d        = 3'd6;
                     coarse_dec_d = 1'b1;
                     rev_cnt_d    = 8'd0;
                  end else begin
                     lvl_d     = lvl_q - 3'd1;
                     rev_cnt_d = (last_dir_q == DIR_UP) ? rev_inc : 8'd0;
                  end
               end else begin
                  rev_cnt_d = rev_inc;
               end
               lock_d = (rev_cnt_d >= LOCK_TH);
            end
            S_SETTLE: begin
               set_cnt_d = set_cnt_q + 16'd1;
               if (set_cnt_q == SET_LAST) begin
                  state_d   = S_ACCUM;
                  smp_cnt_d = 8'd0;
                  up_cnt_d  = 8'd0;
                  dn_cnt_d  = 8'd0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      q_d = ALL_ONES << (3'd6 - lvl_d);
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_dir_q   <= DIR_NONE;
         smp_cnt_q    <= 8'd0;
         up_cnt_q     <= 8'd0;
         dn_cnt_q     <= 8'd0;
         set_cnt_q    <= 16'd0;
         rev_cnt_q    <= 8'd0;
         lvl_q        <= 3'd3;
         q_q          <= 6'b111000;
         update_q     <= 1'b0;
         coarse_inc_q <= 1'b0;
         coarse_dec_q <= 1'b0;
         lock_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_dir_q   <= last_dir_d;
         smp_cnt_q    <= smp_cnt_d;
         up_cnt_q     <= up_cnt_d;
         dn_cnt_q     <= dn_cnt_d;
         set_cnt_q    <= set_cnt_d;
         rev_cnt_q    <= rev_cnt_d;
         lvl_q        <= lvl_d;
         q_q          <= q_d;
         update_q     <= update_d;
         coarse_inc_q <= coarse_inc_d;
         coarse_dec_q <= coarse_dec_d;
         lock_q       <= lock_d;
      end
   end

   assign Q          = q_q;
   assign update     = update_q;
   assign coarse_inc = coarse_inc_q;
   assign coarse_dec = coarse_dec_q;
   assign lock       = lock_q;

endmodule

// File: doc/fdl_thermo_ctrl.md
# fdl_thermo_ctrl

Digital loop controller driving the 6-bit thermometer control word of the fine delay line (FDL) in the FMDLL. It filters the phase-detector up/down decisions over a fixed window, then steps the thermometer code one level. It emits one-cycle carry/borrow pulses to the coarse delay stage when the fine range wraps, and flags lock once the loop dithers around its final position.

## Interface
- `FILT_LEN`, 8: phase-detector samples per decision window (2..255).
- `VOTE_TH`, 5: minimum votes for a step (must be > FILT_LEN/2 and ≤ FILT_LEN).
- `SETTLE`, 4: idle cycles after each decision before the next window opens (≥ 1).
- `LOCK_CNT`, 4: non-monotonic decisions needed to assert lock (≥ 1).
- `clk_in`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `en`  in  1  loop enable.
- `pd_up`  in  1  phase detector asks for more delay; synchronous to `clk_in`.
- `pd_dn`  in  1  phase detector asks for less delay; synchronous to `clk_in`.
- `Q`  out  6  thermometer code to the FDL, registered.
- `update`  out  1  one-cycle pulse when `Q` changes.
- `coarse_inc`  out  1  one-cycle pulse; fine range overflowed upward.
- `coarse_dec`  out  1  one-cycle pulse; fine range underflowed downward.
- `lock`  out  1  loop locked, registered.

## Operation
- **Level L (0..6) and Q encoding.** Internal level L maps to `Q` as ones filled from the MSB, `Q = 6'b111111 << (6-L)`.
  - Example encodings: L=0 gives 000000, L=1 gives 100000, L=6 gives 111111.
  - Higher L means more delay. `Q` never leaves thermometer form.
- **Reset.**
  - L=3, so `Q`=111000.
  - `update`, `coarse_inc`, `coarse_dec` and `lock` are 0.
  - State is IDLE, and all counters are 0.
- **IDLE:** `Q` is held and pd inputs are ignored. With `en`=1, go to ACCUM and clear `up_cnt`, `dn_cnt` and the sample counter.
- **ACCUM:** runs for exactly FILT_LEN cycles. Each cycle:
  - `pd_up & ~pd_dn` increments `up_cnt`.
  - `pd_dn & ~pd_up` increments `dn_cnt`.
  - Both high, or both low, casts no vote.
  - After FILT_LEN samples, go to DECIDE.
- **DECIDE (1 cycle):** pick the decision, then go to SETTLE.
  - UP if `up_cnt` ≥ VOTE_TH.
  - Otherwise DOWN if `dn_cnt` ≥ VOTE_TH.
  - Otherwise HOLD.
- **Applying the decision:**
  - UP with L<6: L+1.
  - UP with L=6: L=0 and pulse `coarse_inc`.
  - DOWN with L>0: L-1.
  - DOWN with L=0: L=6 and pulse `coarse_dec`.
  - HOLD: no change and no pulse.
- **SETTLE:** counts SETTLE cycles, during which pd inputs are ignored. Then go to ACCUM (counters cleared) if `en`=1, else IDLE.
- **Lock tracking.** The block keeps `last_dir` (UP/DOWN/none) and a saturating `rev_cnt`.
  - A step opposite `last_dir`, or a HOLD, increments `rev_cnt`.
  - A step equal to `last_dir` clears `rev_cnt`.
  - A coarse carry/borrow clears `rev_cnt`.
  - Every step updates `last_dir`. HOLD leaves `last_dir` unchanged.
  - `lock` = (`rev_cnt` ≥ LOCK_CNT), registered. It is updated at the same edge as the decision.
- **`en` deasserted in any state.**
  - Next edge goes to IDLE, and the current window is discarded.
  - `Q` and `last_dir` are retained. `rev_cnt` and `lock` are cleared.
  - A DECIDE cycle coinciding with `en`=0 is not applied.
- **`rst` precedence:** `rst` overrides `en` and all state.

## Timing
- `en` is sampled 1 at edge k. ACCUM samples pd on cycles k+1..k+FILT_LEN, and DECIDE occupies cycle k+FILT_LEN+1.
- New `Q`, `update`, any coarse pulse and new `lock` all appear after the edge ending DECIDE. They are simultaneous, and each pulse lasts exactly 1 cycle.
- Decision period in continuous operation is FILT_LEN+1+SETTLE cycles (13 with defaults).
- At most one level change per period, so `Q` changes by one thermometer bit, except on wrap.
- `Q` has no combinational path from any input.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `en`=1 and pd toggling -> `Q`=111000; `update`/`coarse_*`/`lock` are 0. The first window starts the cycle after release.
- **Constant `pd_up`=1, `pd_dn`=0:**
  - `Q` steps 111100, 111110, 111111 at 13-cycle intervals, with `update` pulsing each time.
  - The next decision gives `Q`=000000 with `coarse_inc`=1 and `update`=1 for one cycle.
  - `lock` stays 0.
- **Constant `pd_dn`=1:** `Q` steps 110000, 100000, 000000, then 111111 with `coarse_dec`=1 for one cycle.
- **Sub-threshold windows:**
  - Each window carries 4 up votes plus 4 cycles with both high.
  - Required: `Q` holds 111000 and `update` never pulses.
  - `lock`=1 after the 4th decision.
- **Alternating windows (8 up, then 8 dn, ...):**
  - `Q` toggles 111100/111000, and `lock` rises after the 5th decision (4 reversals).
  - Two consecutive all-up windows then produce a same-direction step, and `lock` falls at that decision.
- **`en` dropped at the 5th ACCUM cycle:**
  - Next cycle is IDLE, `Q` is unchanged, `lock`=0, and no `update` pulse.
  - Re-raising `en` starts a fresh full 8-sample window.
